gpio_input_conditioner: RTL
===========================

Name: gpio_input_conditioner

Overview:
Parametrised successor to the single-button debouncer used at the FPGA top level. It takes CHANNELS raw board inputs (buttons, keys), synchronises and debounces each one, and can optionally auto-repeat each one. Press, release and repeat events are queued per channel and presented on a valid/ready event port. The SoC top drives gpio_i from the debounced levels and feeds the keycode stepper and pause logic from the event port.

Parameters:
CHANNELS, 4, number of input channels (1..16)
STABLE_CYCLES, 40, consecutive cycles a changed input must hold before the debounced level flips (>=2)
CNT_WIDTH, 16, width of the per-channel debounce and repeat counters; must hold max(STABLE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)
INVERT_MASK, 0, per-channel bit; 1 = pin is active-low and is inverted after synchronisation
REPEAT_MASK, 0, per-channel bit; 1 = auto-repeat enabled
REPEAT_DELAY, 12500, cycles from the press event to the first repeat event
REPEAT_PERIOD, 2500, cycles between subsequent repeat events

Ports:
clk  in  1  system clock (video/SoC clock)
reset_n  in  1  synchronous active-low reset
enable  in  1  0 = freeze all counters and inhibit new events; the pending queue still drains
btn_i  in  CHANNELS  raw asynchronous pin levels
debounced_o  out  CHANNELS  debounced active-high levels
evt_valid  out  1  an event is presented
evt_ready  in  1  consumer accepts the event on a cycle where evt_valid=1
evt_channel  out  4  channel index of the presented event
evt_kind  out  2  event kind: 01 = press, 10 = release, 11 = repeat
overflow_o  out  1  sticky flag: an event was lost

Behaviour:
- Reset, checked on each clk edge while reset_n=0:
  - debounced_o=0, evt_valid=0, evt_channel=0, evt_kind=0, overflow_o=0.
  - All counters=0 and all pending bits=0.
  - Synchroniser flops load INVERT_MASK, so the post-inversion sample is 0 and no spurious event follows reset.
- Synchroniser: two flops per channel, s1<=btn_i and s2<=s1. The sample is s2 XOR INVERT_MASK[ch].
- Debounce, per channel, only when enable=1:
  - sample==debounced: counter cleared.
  - sample!=debounced and counter==STABLE_CYCLES-1: debounced flips and the counter clears.
  - Otherwise the counter increments.
- Debounce latency: a pin change held stable is visible on debounced_o after exactly STABLE_CYCLES+2 rising edges, counting from the first edge that samples it. A glitch shorter than STABLE_CYCLES samples produces no change.
- A 0->1 flip raises a press event; a 1->0 flip raises a release event.
- Repeat, only for channels with REPEAT_MASK=1 and enable=1:
  - While debounced=1, the repeat counter counts from the press flip.
  - Reaching REPEAT_DELAY raises a repeat event, and the counter reloads so that each later repeat fires every REPEAT_PERIOD cycles.
  - A release flip clears the repeat counter immediately; no repeat fires on the cycle of the release.
- Pending store: three bits per channel (press, release, repeat). A new event sets its bit.
- Selection (evt_valid=0, or evt_valid=1 with evt_ready=1):
  - Lowest channel index with any pending bit wins.
  - Within a channel the order is press, then release, then repeat.
  - The selected bit clears, and evt_* register the choice on the next edge.
  - Event latency: press flip at edge N gives evt_valid=1 after edge N+1 when the queue is idle.
- Handshake:
  - evt_channel and evt_kind hold stable while evt_valid=1 and evt_ready=0.
  - Back-to-back events are allowed: one per cycle with ready held high.
- Overflow:
  - If a new event targets a pending bit that is already set, overflow_o goes to 1 and stays there until reset. The new event merges into the existing bit.
  - If the same bit is dequeued and newly set on the same edge, the bit stays 1 and overflow is not set.
- enable=0 mid-count: counters hold their values. Synchronisers keep running.
- reset_n=0 mid-handshake: evt_valid drops on that edge and queued events are discarded.

Decomposition:
- Package gpio_input_pkg:
  - EVT_PRESS=2'b01, EVT_RELEASE=2'b10, EVT_REPEAT=2'b11.
  - Event-kind typedef (2-bit).
  - Maximum channel count, 16.
- Sub-module debounce_channel contains the synchroniser, debounce counter and repeat counter, and emits press/release/repeat strobes. It is instantiated CHANNELS times with a generate loop.
- The top level holds the pending store, priority select and event output register.

Test Plan:
- Reset, all inputs 0: outputs all 0, no events for 1000 cycles. With INVERT_MASK=4'b0001 and btn_i[0]=1 held through reset, there is no press event.
- STABLE_CYCLES=40, btn_i[1] rises and holds: debounced_o[1]=1 after exactly 42 edges, then evt_valid=1 with channel=1, kind=01 on the next edge.
- btn_i[2] glitches high for 39 cycles: no change on debounced_o and no event. A 40-cycle pulse produces press then release events.
- REPEAT_MASK=4'b1000, REPEAT_DELAY=100, REPEAT_PERIOD=20, ch3 held 200 cycles after the press: repeats at +100, +120, ... +180, i.e. 5 repeat events. Release gives one release event and no further repeats.
- Channels 0 and 3 press on the same cycle, evt_ready=0 for 10 cycles: ch0 press is held stable, then ch3 press follows on the cycle after ready.
- Hold evt_ready=0 and toggle ch0 twice (two presses): overflow_o=1, only one press is queued for ch0, and the flag survives until reset_n=0.

Source files
------------

// File: rtl/gpio_input_pkg.sv
// Shared definitions for the GPIO input conditioner:
// event encodings and channel limits.
package gpio_input_pkg;

    localparam int MAX_CHANNELS = 16;

    typedef logic [1:0] evt_kind_t;

    localparam evt_kind_t EVT_NONE    = 2'b00;
    localparam evt_kind_t EVT_PRESS   = 2'b01;
    localparam evt_kind_t EVT_RELEASE = 2'b10;
    localparam evt_kind_t EVT_REPEAT  = 2'b11;

endpackage

// File: rtl/debounce_channel.sv
// One input channel: two-flop synchroniser, debounce counter
// and optional auto-repeat counter, emitting event strobes.
module debounce_channel
    import gpio_input_pkg::*;
#(
    parameter int   STABLE_CYCLES = 40,
    parameter int   CNT_WIDTH     = 16,
    parameter logic INVERT        = 1'b0,
    parameter logic REPEAT_EN     = 1'b0,
    parameter int   REPEAT_DELAY  = 12500,
    parameter int   REPEAT_PERIOD = 2500
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic btn,
    output logic debounced,
    output logic press,
    output logic rel,
    output logic rpt
);

    localparam logic [CNT_WIDTH-1:0] STABLE_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] RPT_LAST    = CNT_WIDTH'(REPEAT_DELAY - 1);
    localparam logic [CNT_WIDTH-1:0] RPT_RELOAD  = CNT_WIDTH'(REPEAT_DELAY - REPEAT_PERIOD);

    logic                 s1;
    logic                 s2;
    logic                 sample;
    logic                 flip;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] rcnt;

    assign sample = s2 ^ INVERT;
    assign flip   = enable && (sample != debounced) && (cnt == STABLE_LAST);
    assign press  = flip && !debounced;
    assign rel    = flip && debounced;
    // A release on this cycle wins over a repeat that would coincide.
    assign rpt    = REPEAT_EN && enable && debounced && !flip && (rcnt == RPT_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1        <= INVERT;
            s2        <= INVERT;
            debounced <= 1'b0;
            cnt       <= '0;
            rcnt      <= '0;
        end else begin
            s1 <= btn;
            s2 <= s1;
            if (enable) begin
                if (sample == debounced) begin
                    cnt <= '0;
                end else if (flip) begin
                    cnt       <= '0;
                    debounced <= !debounced;
                end else begin
                    cnt <= cnt + 1'b1;
                end

                if (!REPEAT_EN || !debounced || flip) begin
                    rcnt <= '0;
                end else if (rpt) begin
                    rcnt <= RPT_RELOAD;
                end else begin
                    rcnt <= rcnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/gpio_input_conditioner.sv
// Multi-channel debounced GPIO inputs with a per-channel pending
// event store and a valid/ready event port.
module gpio_input_conditioner
    import gpio_input_pkg::*;
#(
    parameter int                  CHANNELS      = 4,
    parameter int                  STABLE_CYCLES = 40,
    parameter int                  CNT_WIDTH     = 16,
    parameter logic [CHANNELS-1:0] INVERT_MASK   = '0,
    parameter logic [CHANNELS-1:0] REPEAT_MASK   = '0,
    parameter int                  REPEAT_DELAY  = 12500,
    parameter int                  REPEAT_PERIOD = 2500
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [CHANNELS-1:0] btn_i,
    output logic [CHANNELS-1:0] debounced_o,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [3:0]          evt_channel,
    output logic [1:0]          evt_kind,
    output logic                overflow_o
);

    logic [CHANNELS-1:0] press;
    logic [CHANNELS-1:0] rel;
    logic [CHANNELS-1:0] rpt;
    logic [CHANNELS-1:0] pend_p;
    logic [CHANNELS-1:0] pend_r;
    logic [CHANNELS-1:0] pend_t;
    logic [CHANNELS-1:0] clr_p;
    logic [CHANNELS-1:0] clr_r;
    logic [CHANNELS-1:0] clr_t;
    logic [CHANNELS-1:0] keep_p;
    logic [CHANNELS-1:0] keep_r;
    logic [CHANNELS-1:0] keep_t;
    logic [CHANNELS-1:0] sel_oh;
    logic                sel_found;
    logic [3:0]          sel_ch;
    evt_kind_t           sel_kind;
    logic                take;
    logic                lost;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .CNT_WIDTH     (CNT_WIDTH),
            .INVERT        (INVERT_MASK[i]),
            .REPEAT_EN     (REPEAT_MASK[i]),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_ch (
            .clk       (clk),
            .reset_n   (reset_n),
            .enable    (enable),
            .btn       (btn_i[i]),
            .debounced (debounced_o[i]),
            .press     (press[i]),
            .rel       (rel[i]),
            .rpt       (rpt[i])
        );
    end

    assign take = !evt_valid || evt_ready;

    // Scan downward so the lowest pending channel is the last to win.
    always_comb begin
        sel_found = 1'b0;
        sel_ch    = '0;
        sel_kind  = EVT_NONE;
        sel_oh    = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (pend_p[i] || pend_r[i] || pend_t[i]) begin
                sel_found = 1'b1;
                sel_ch    = 4'(i);
                sel_oh    = '0;
                sel_oh[i] = 1'b1;
                if (pend_p[i]) begin
                    sel_kind = EVT_PRESS;
                end else if (pend_r[i]) begin
                    sel_kind = EVT_RELEASE;
                end else begin
                    sel_kind = EVT_REPEAT;
                end
            end
        end
    end

    always_comb begin
        clr_p = '0;
        clr_r = '0;
        clr_t = '0;
        if (take && sel_found) begin
            unique case (sel_kind)
                EVT_PRESS:   clr_p = sel_oh;
                EVT_RELEASE: clr_r = sel_oh;
                EVT_REPEAT:  clr_t = sel_oh;
                default:     clr_p = '0;
            endcase
        end
    end

    assign keep_p = pend_p & ~clr_p;
    assign keep_r = pend_r & ~clr_r;
    assign keep_t = pend_t & ~clr_t;
    assign lost   = |((keep_p & press) | (keep_r & rel) | (keep_t & rpt));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pend_p      <= '0;
            pend_r      <= '0;
            pend_t      <= '0;
            evt_valid   <= 1'b0;
            evt_channel <= '0;
            evt_kind    <= EVT_NONE;
            overflow_o  <= 1'b0;
        end else begin
            pend_p <= keep_p | press;
            pend_r <= keep_r | rel;
            pend_t <= keep_t | rpt;
            if (lost) begin
                overflow_o <= 1'b1;
            end
            if (take) begin
                evt_valid <= sel_found;
                if (sel_found) begin
                    evt_channel <= sel_ch;
                    evt_kind    <= sel_kind;
                end
            end
        end
    end

endmodule
